// File: rtl/trig_type_lv1b_multi.sv
// trig_type_lv1b_multi
//   Evaluates N_CH Level-1B trigger types against the shared LV1A / LV1B
//   request strobe and cluster count. Each type has its own cluster mask,
//   p/q prescaler, enable and saturating raw/scaled counters. A shared
//   holdoff suppresses scaled outputs for user_holdoff cycles after any
//   scaled trigger is issued.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_live              run live level; rising edge = run start (clears state)
//   in_ena/in_lv1b_req/in_lv1a/in_nclus   trigger qualifiers
//   user_nclus/_prescale_p/_prescale_q/_ena   per-type config (packed)
//   user_holdoff         shared holdoff length, 0 disables
//   out_lv1b_raw/_scaled per-type registered pulses
//   out_lv1b_any         OR of scaled pulses
//   out_trig_type        lowest scaled index (0 when none)
//   out_busy             holdoff active
//   raw_cnt/scaled_cnt   per-type saturating counters (packed)

// Per-type prescaler and counters.
module trig_type_lv1b_lane #(
    parameter int P_W   = 10,
    parameter int Q_W   = 12,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_start,
    input  logic             qual,
    input  logic             scaled,
    input  logic [P_W-1:0]   p,
    input  logic [Q_W-1:0]   q,
    output logic             pass,
    output logic [CNT_W-1:0] raw_cnt,
    output logic [CNT_W-1:0] scaled_cnt
);
    logic [Q_W-1:0]   pc_q, pc_d, pc_base;
    logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d, scaled_cnt_q, scaled_cnt_d;
    logic [CNT_W-1:0] raw_base, scaled_base;

    // Prescale decision; run start evaluates from a cleared counter.
    always_comb begin
        pc_base = run_start ? '0 : pc_q;
        pass    = qual && (pc_base < Q_W'(p));
        pc_d    = pc_base;
        if (qual) begin
            if (q < Q_W'(2))                 pc_d = '0;
            else if (pc_base < q - Q_W'(1))  pc_d = pc_base + Q_W'(1);
            else                             pc_d = '0;
        end
    end

    // Kept apart from the block above: scaled depends on pass via the top.
    always_comb begin
        raw_base     = run_start ? '0 : raw_cnt_q;
        scaled_base  = run_start ? '0 : scaled_cnt_q;
        raw_cnt_d    = raw_base;
        scaled_cnt_d = scaled_base;
        if (qual && !(&raw_base))      raw_cnt_d    = raw_base + CNT_W'(1);
        if (scaled && !(&scaled_base)) scaled_cnt_d = scaled_base + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            raw_cnt_q    <= '0;
            scaled_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            raw_cnt_q    <= raw_cnt_d;
            scaled_cnt_q <= scaled_cnt_d;
        end
    end

    assign raw_cnt    = raw_cnt_q;
    assign scaled_cnt = scaled_cnt_q;
endmodule

module trig_type_lv1b_multi #(
    parameter int N_CH    = 4,
    parameter int NCLUS_W = 4,
    parameter int MASK_W  = 10,
    parameter int P_W     = 10,
    parameter int Q_W     = 12,
    parameter int CNT_W   = 32,
    parameter int HOLD_W  = 8,
    parameter int TYPE_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_live,
    input  logic                    in_ena,
    input  logic                    in_lv1b_req,
    input  logic                    in_lv1a,
    input  logic [NCLUS_W-1:0]      in_nclus,
    input  logic [N_CH*MASK_W-1:0]  user_nclus,
    input  logic [N_CH*P_W-1:0]     user_prescale_p,
    input  logic [N_CH*Q_W-1:0]     user_prescale_q,
    input  logic [N_CH-1:0]         user_ena,
    input  logic [HOLD_W-1:0]       user_holdoff,
    output logic [N_CH-1:0]         out_lv1b_raw,
    output logic [N_CH-1:0]         out_lv1b_scaled,
    output logic                    out_lv1b_any,
    output logic [TYPE_W-1:0]       out_trig_type,
    output logic                    out_busy,
    output logic [N_CH*CNT_W-1:0]   raw_cnt,
    output logic [N_CH*CNT_W-1:0]   scaled_cnt
);
    logic                pre_live_q, pre_live_d;
    logic [HOLD_W-1:0]   hc_q, hc_d, hc_base;
    logic                run_start;
    logic [N_CH-1:0]     qual, pass, scaled;
    logic [N_CH-1:0]     raw_q, scaled_q;
    logic                any_q, any_d, busy_q, busy_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    int unsigned         nc;

    // Qualification: nclus saturates at the top mask bit.
    always_comb begin
        logic [MASK_W-1:0] sh;
        sh         = '0;
        pre_live_d = in_live;
        run_start  = in_live & ~pre_live_q;
        nc         = 32'(in_nclus);
        if (nc > 32'(MASK_W - 1)) nc = 32'(MASK_W - 1);
        for (int i = 0; i < N_CH; i++) begin
            sh      = user_nclus[i*MASK_W +: MASK_W] >> nc;
            qual[i] = in_ena & in_lv1b_req & in_lv1a & user_ena[i] & sh[0];
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_lane
            trig_type_lv1b_lane #(.P_W(P_W), .Q_W(Q_W), .CNT_W(CNT_W)) u_lane (
                .clk        (clk),
                .rst        (rst),
                .run_start  (run_start),
                .qual       (qual[g]),
                .scaled     (scaled[g]),
                .p          (user_prescale_p[g*P_W +: P_W]),
                .q          (user_prescale_q[g*Q_W +: Q_W]),
                .pass       (pass[g]),
                .raw_cnt    (raw_cnt[g*CNT_W +: CNT_W]),
                .scaled_cnt (scaled_cnt[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Holdoff gating, shared across types.
    always_comb begin
        hc_base = run_start ? '0 : hc_q;
        scaled  = pass & {N_CH{hc_base == '0}};
        any_d   = |scaled;
        if (any_d && (user_holdoff != '0)) hc_d = user_holdoff;
        else if (hc_base != '0)            hc_d = hc_base - HOLD_W'(1);
        else                               hc_d = '0;
        busy_d  = (hc_d != '0);
        type_d  = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (scaled[i]) type_d = TYPE_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_live_q <= 1'b0;
            hc_q       <= '0;
            raw_q      <= '0;
            scaled_q   <= '0;
            any_q      <= 1'b0;
            busy_q     <= 1'b0;
            type_q     <= '0;
        end else begin
            pre_live_q <= pre_live_d;
            hc_q       <= hc_d;
            raw_q      <= qual;
            scaled_q   <= scaled;
            any_q      <= any_d;
            busy_q     <= busy_d;
            type_q     <= type_d;
        end
    end

    assign out_lv1b_raw    = raw_q;
    assign out_lv1b_scaled = scaled_q;
    assign out_lv1b_any    = any_q;
    assign out_trig_type   = type_q;
    assign out_busy        = busy_q;
endmodule

// File: tb/tb_trig_type_lv1b_multi.sv
module tb_trig_type_lv1b_multi;
    localparam int N = 4, MW = 10, PW = 10, QW = 12, CW = 32, HW = 8, TW = 2;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_live, in_ena, in_lv1b_req, in_lv1a;
    logic [3:0]      in_nclus;
    logic [N*MW-1:0] user_nclus;
    logic [N*PW-1:0] user_prescale_p;
    logic [N*QW-1:0] user_prescale_q;
    logic [N-1:0]    user_ena;
    logic [HW-1:0]   user_holdoff;

    logic [N-1:0]    out_lv1b_raw, out_lv1b_scaled;
    logic            out_lv1b_any, out_busy;
    logic [TW-1:0]   out_trig_type;
    logic [N*CW-1:0] raw_cnt, scaled_cnt;

    logic [N-1:0]    s_raw, s_scaled;
    logic            s_any, s_busy;
    logic [TW-1:0]   s_type;
    logic [N*4-1:0]  s_raw_cnt, s_scaled_cnt;

    trig_type_lv1b_multi dut (
        .clk(clk), .rst(rst), .in_live(in_live), .in_ena(in_ena),
        .in_lv1b_req(in_lv1b_req), .in_lv1a(in_lv1a), .in_nclus(in_nclus),
        .user_nclus(user_nclus), .user_prescale_p(user_prescale_p),
        .user_prescale_q(user_prescale_q), .user_ena(user_ena),
        .user_holdoff(user_holdoff), .out_lv1b_raw(out_lv1b_raw),
        .out_lv1b_scaled(out_lv1b_scaled), .out_lv1b_any(out_lv1b_any),
        .out_trig_type(out_trig_type), .out_busy(out_busy),
        .raw_cnt(raw_cnt), .scaled_cnt(scaled_cnt));

    // Narrow-counter build for the saturation check.
    trig_type_lv1b_multi #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_live(in_live), .in_ena(in_ena),
        .in_lv1b_req(in_lv1b_req), .in_lv1a(in_lv1a), .in_nclus(in_nclus),
        .user_nclus(user_nclus), .user_prescale_p(user_prescale_p),
        .user_prescale_q(user_prescale_q), .user_ena(user_ena),
        .user_holdoff(user_holdoff), .out_lv1b_raw(s_raw),
        .out_lv1b_scaled(s_scaled), .out_lv1b_any(s_any),
        .out_trig_type(s_type), .out_busy(s_busy),
        .raw_cnt(s_raw_cnt), .scaled_cnt(s_scaled_cnt));

    int checks = 0, failures = 0;

    // Reference model state
    bit      m_live;
    int      m_pc[N];
    int      m_hc;
    longint  m_raw[N], m_sc[N];
    logic [N-1:0]  e_raw, e_sc;
    logic          e_busy;
    logic [TW-1:0] e_type;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int nc, p, q;
        bit hold;
        e_raw = '0; e_sc = '0; e_type = '0; e_busy = 1'b0;
        if (rst) begin
            m_live = 0; m_hc = 0;
            for (int i = 0; i < N; i++) begin m_pc[i] = 0; m_raw[i] = 0; m_sc[i] = 0; end
            return;
        end
        if (in_live && !m_live) begin
            m_hc = 0;
            for (int i = 0; i < N; i++) begin m_pc[i] = 0; m_raw[i] = 0; m_sc[i] = 0; end
        end
        m_live = in_live;
        nc   = (int'(in_nclus) > MW - 1) ? MW - 1 : int'(in_nclus);
        hold = (m_hc != 0);
        for (int i = 0; i < N; i++) begin
            p = int'(user_prescale_p[i*PW +: PW]);
            q = int'(user_prescale_q[i*QW +: QW]);
            if (!(in_ena && in_lv1b_req && in_lv1a && user_ena[i] && user_nclus[i*MW + nc])) continue;
            e_raw[i] = 1'b1;
            if (m_raw[i] < CMAX) m_raw[i]++;
            if (m_pc[i] < p && !hold) begin
                e_sc[i] = 1'b1;
                if (m_sc[i] < CMAX) m_sc[i]++;
            end
            m_pc[i] = (q > 1 && m_pc[i] < q - 1) ? m_pc[i] + 1 : 0;
        end
        for (int i = N - 1; i >= 0; i--) if (e_sc[i]) e_type = TW'(i);
        if (e_sc != 0 && user_holdoff != 0) m_hc = int'(user_holdoff);
        else if (m_hc > 0) m_hc--;
        e_busy = (m_hc != 0);
    endtask

    // One clock: model consumes the same inputs the DUT samples, compare #1 later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("raw",    out_lv1b_raw,    e_raw);
        chk("scaled", out_lv1b_scaled, e_sc);
        chk("any",    out_lv1b_any,    |e_sc);
        chk("type",   out_trig_type,   e_type);
        chk("busy",   out_busy,        e_busy);
        for (int i = 0; i < N; i++) begin
            chk("raw_cnt",    raw_cnt[i*CW +: CW],    m_raw[i]);
            chk("scaled_cnt", scaled_cnt[i*CW +: CW], m_sc[i]);
        end
    endtask

    task automatic trig(input bit on);
        in_ena = on; in_lv1b_req = on; in_lv1a = on;
    endtask

    task automatic restart();
        trig(0); in_live = 0; tick(); in_live = 1; tick();
    endtask

    task automatic set_pq(input int i, input int p, input int q);
        user_prescale_p[i*PW +: PW] = PW'(p);
        user_prescale_q[i*QW +: QW] = QW'(q);
    endtask

    initial begin
        logic [9:0]  pat;
        logic [13:0] bpat;
        int cnt;
        rst = 1; in_live = 0; trig(0); in_nclus = 3;
        user_nclus = '1; user_ena = '0; user_holdoff = '0;
        for (int i = 0; i < N; i++) set_pq(i, 1, 1);

        // Reset then run start, single type-0 trigger
        tick(); tick();
        rst = 0; tick();
        in_live = 1; tick();
        user_ena = 4'b0001; trig(1); tick();
        chk("t0_raw", out_lv1b_raw, 4'b0001);
        chk("t0_scaled", out_lv1b_scaled, 4'b0001);
        chk("t0_type", out_trig_type, 0);
        chk("t0_rawcnt", raw_cnt[CW-1:0], 1);
        chk("t0_sccnt", scaled_cnt[CW-1:0], 1);
        trig(0); tick();
        chk("t0_pulse_end", out_lv1b_raw, 4'b0000);

        // Prescale p=2 q=5 on type 1
        restart(); user_ena = 4'b0010; set_pq(1, 2, 5); trig(1);
        pat = '0;
        for (int k = 0; k < 10; k++) begin tick(); pat = {pat[8:0], out_lv1b_scaled[1]}; end
        chk("ps_pattern", pat, 10'b1100011000);
        chk("ps_sccnt", scaled_cnt[CW +: CW], 4);
        chk("ps_rawcnt", raw_cnt[CW +: CW], 10);
        restart(); set_pq(1, 0, 5); trig(1);
        for (int k = 0; k < 10; k++) tick();
        chk("ps_p0", scaled_cnt[CW +: CW], 0);
        restart(); set_pq(1, 2, 0); trig(1);
        for (int k = 0; k < 10; k++) tick();
        chk("ps_q0", scaled_cnt[CW +: CW], 10);

        // Cluster mask sweep on type 2
        restart(); user_ena = 4'b0100; user_nclus[2*MW +: MW] = 10'b10_0000_0100; trig(1);
        cnt = 0;
        for (int n = 0; n < 16; n++) begin in_nclus = 4'(n); tick(); cnt += int'(out_lv1b_raw[2]); end
        chk("mask_pulses", cnt, 8);
        chk("mask_rawcnt", raw_cnt[2*CW +: CW], 8);
        user_nclus = '1; in_nclus = 3;

        // Holdoff 3, all types passing
        restart(); user_ena = 4'b1111; set_pq(1, 1, 1); user_holdoff = 3; trig(1);
        pat = '0; bpat = '0;
        for (int k = 0; k < 14; k++) begin
            if (k == 10) trig(0);
            tick();
            if (k < 10) pat = {pat[8:0], out_lv1b_any};
            bpat = {bpat[12:0], out_busy};
        end
        chk("hold_any", pat, 10'b1000100010);
        chk("hold_busy", bpat, 14'b11101110111000);
        for (int i = 0; i < N; i++) chk("hold_rawcnt", raw_cnt[i*CW +: CW], 10);
        user_holdoff = 0;

        // Simultaneous types 1 and 3
        restart(); user_ena = 4'b1010; trig(1); tick();
        chk("sim_scaled", out_lv1b_scaled, 4'b1010);
        chk("sim_type", out_trig_type, 1);
        chk("sim_any", out_lv1b_any, 1);
        // Run restart with a trigger in the same cycle
        trig(0); in_live = 0; tick();
        in_live = 1; trig(1); tick();
        chk("rs_rawcnt1", raw_cnt[CW +: CW], 1);
        chk("rs_rawcnt3", raw_cnt[3*CW +: CW], 1);
        chk("rs_sccnt1", scaled_cnt[CW +: CW], 1);
        trig(0); tick();

        // Saturation in the 4-bit counter build
        restart(); user_ena = 4'b0001; trig(1);
        for (int k = 0; k < 20; k++) tick();
        chk("sat_rawcnt", s_raw_cnt[3:0], 15);
        chk("sat_sccnt", s_scaled_cnt[3:0], 15);
        chk("nosat_rawcnt", raw_cnt[CW-1:0], 20);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) begin
                for (int i = 0; i < N; i++) set_pq(i, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
                user_nclus   = {$urandom, $urandom};
                user_ena     = 4'($urandom);
                user_holdoff = 8'($urandom_range(0, 4));
            end
            in_ena      = ($urandom_range(0, 7) != 0);
            in_lv1b_req = ($urandom_range(0, 3) != 0);
            in_lv1a     = ($urandom_range(0, 3) != 0);
            in_nclus    = 4'($urandom);
            if ($urandom_range(0, 39) == 0) in_live = ~in_live;
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
